// File: rtl/reshape_frame_streamer_if.sv
// Pixel stream bus out of reshape_frame_streamer.
// master: the streamer (drives valid/data/markers), slave: the downstream sink.
interface reshape_frame_streamer_if #(
  parameter int DW = 8
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          sof;
  logic          eol;
  logic          eof;

  modport master (output valid, data, sof, eol, eof, input ready);
  modport slave  (input valid, data, sof, eol, eof, output ready);
endinterface

// File: rtl/reshape_frame_streamer.sv
// reshape_frame_streamer: captures the reshaper write port into two ping-pong
// DST_W x DST_H frame banks and streams each completed bank in raster order.
// Optional feature macro: STREAM_CHECKSUM_EN (per-frame 16-bit pixel sum).
module reshape_frame_streamer #(
  parameter int DST_W = 260,
  parameter int DST_H = 260,
  parameter int AW    = 20,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     frame_start,
  input  logic                     in_wr_en,
  input  logic [AW-1:0]            in_wr_addr,
  input  logic [DW-1:0]            in_wr_data,
  output logic                     buf_ready,
  reshape_frame_streamer_if.master m,
  output logic                     ovf_err,
  output logic [15:0]              frame_sum,
  output logic                     sum_valid
);
  localparam int NPIX = DST_W * DST_H;
  localparam int IW   = (NPIX  > 1) ? $clog2(NPIX)  : 1;
  localparam int CW   = (DST_W > 1) ? $clog2(DST_W) : 1;
  localparam int RW   = (DST_H > 1) ? $clog2(DST_H) : 1;
  localparam logic [AW-1:0] LAST_A = AW'(NPIX - 1);
  localparam logic [CW-1:0] LAST_C = CW'(DST_W - 1);
  localparam logic [RW-1:0] LAST_R = RW'(DST_H - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_STREAMING} bank_e;
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} rd_e;

  // frame storage
  logic [DW-1:0] mem0 [NPIX];
  logic [DW-1:0] mem1 [NPIX];

  // bank bookkeeping
  bank_e bank_st  [2];
  bank_e bank_nxt [2];
  logic  wr_bank, wr_bank_nxt;
  logic  rd_bank, rd_bank_nxt;
  logic  buf_ready_nxt;

  // write pipeline
  logic          pend_vld;
  logic [AW-1:0] pend_addr;
  logic          wr_open, wr_ok, wr_last, wr_drop;

  // read side
  rd_e           state, state_nxt;
  logic          start, issue;
  logic [IW-1:0] raddr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          rd_more;
  logic          i_sof, i_eol, i_eof;

  // output stages: r_* is the RAM output register, sk_* the skid entry
  logic          r_vld, r_sof, r_eol, r_eof;
  logic [DW-1:0] r_data;
  logic          sk_vld, sk_sof, sk_eol, sk_eof;
  logic [DW-1:0] sk_data;
  logic          mv_skid;
  logic          out_vld, out_sof, out_eol, out_eof;
  logic [DW-1:0] out_data;
  logic          pop, eof_pop;

  // ---------------------------------------------------------------- write side
  // Commit decisions are made when the data arrives, against the bank that is
  // current at that moment, so a strobe right after a fill lands in the new bank.
  assign wr_open = (bank_st[wr_bank] == B_EMPTY) || (bank_st[wr_bank] == B_FILLING);
  assign wr_ok   = pend_vld && (pend_addr <= LAST_A) && wr_open;
  assign wr_last = wr_ok && (pend_addr == LAST_A);
  assign wr_drop = pend_vld && !wr_ok;

  // Capture the strobed address; its pixel arrives on the following cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
    end else begin
      pend_vld <= in_wr_en;
      if (in_wr_en) pend_addr <= in_wr_addr;
    end
  end

  // Frame bank write port.
  always_ff @(posedge clk) begin
    if (wr_ok && !wr_bank) mem0[pend_addr[IW-1:0]] <= in_wr_data;
    if (wr_ok &&  wr_bank) mem1[pend_addr[IW-1:0]] <= in_wr_data;
  end

  // ---------------------------------------------------------------- read FSM
  assign i_sof = (raddr == '0);
  assign i_eol = (col == LAST_C);
  assign i_eof = i_eol && (row == LAST_R);

  // Read sequencing: wait for a full bank, prime the RAM, then stream.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bank_st[rd_bank] == B_FULL) begin
          start     = 1'b1;
          state_nxt = S_PRIME;
        end
      end
      S_PRIME: begin
        issue     = 1'b1;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        // Only fetch while the skid is free; with ready held high it never
        // fills, so a read goes out every cycle.
        issue = rd_more && !sk_vld;
        if (eof_pop) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bank state, write/read bank pointers, ready and sticky error flags.
  always_comb begin
    bank_nxt    = bank_st;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    if (wr_ok) bank_nxt[wr_bank] = wr_last ? B_FULL : B_FILLING;
    if (wr_last) wr_bank_nxt = ~wr_bank;
    else if (frame_start && bank_nxt[wr_bank] == B_FILLING) bank_nxt[wr_bank] = B_EMPTY;
    if (start) bank_nxt[rd_bank] = B_STREAMING;
    if (eof_pop) begin
      bank_nxt[rd_bank] = B_EMPTY;
      rd_bank_nxt       = ~rd_bank;
    end
    buf_ready_nxt = !((bank_nxt[wr_bank_nxt] == B_FULL) ||
                      (bank_nxt[wr_bank_nxt] == B_STREAMING));
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      buf_ready  <= 1'b1;
      ovf_err    <= 1'b0;
      state      <= S_IDLE;
    end else begin
      bank_st   <= bank_nxt;
      wr_bank   <= wr_bank_nxt;
      rd_bank   <= rd_bank_nxt;
      buf_ready <= buf_ready_nxt;
      ovf_err   <= ovf_err | wr_drop;
      state     <= state_nxt;
    end
  end

  // Raster read counters: linear RAM address plus col/row for the markers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      raddr   <= '0;
      col     <= '0;
      row     <= '0;
      rd_more <= 1'b0;
    end else if (start) begin
      raddr   <= '0;
      col     <= '0;
      row     <= '0;
      rd_more <= 1'b1;
    end else if (issue) begin
      raddr <= raddr + IW'(1);
      if (i_eol) begin
        col <= '0;
        row <= (row == LAST_R) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
      if (i_eof) rd_more <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- output
  // A fresh read overwrites r; if r is still waiting it moves into the skid.
  assign mv_skid = !sk_vld && issue && r_vld && !pop;

  // RAM read port, one-cycle latency into the head stage.
  always_ff @(posedge clk) begin
    if (issue) r_data <= rd_bank ? mem1[raddr] : mem0[raddr];
  end

  // Skid data path (qualified by sk_vld, so no reset needed).
  always_ff @(posedge clk) begin
    if (mv_skid) sk_data <= r_data;
  end

  // Stage valid bits and beat markers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld  <= 1'b0;
      r_sof  <= 1'b0;
      r_eol  <= 1'b0;
      r_eof  <= 1'b0;
      sk_vld <= 1'b0;
      sk_sof <= 1'b0;
      sk_eol <= 1'b0;
      sk_eof <= 1'b0;
    end else begin
      if (issue) begin
        r_vld <= 1'b1;
        r_sof <= i_sof;
        r_eol <= i_eol;
        r_eof <= i_eof;
      end else if (r_vld && !sk_vld && pop) begin
        r_vld <= 1'b0;
      end
      if (mv_skid) begin
        sk_vld <= 1'b1;
        sk_sof <= r_sof;
        sk_eol <= r_eol;
        sk_eof <= r_eof;
      end else if (sk_vld && pop) begin
        sk_vld <= 1'b0;
      end
    end
  end

  // Skid entry is always older than r, so it has priority at the output.
  assign out_vld  = r_vld | sk_vld;
  assign out_data = sk_vld ? sk_data : (r_vld ? r_data : '0);
  assign out_sof  = sk_vld ? sk_sof  : (r_vld & r_sof);
  assign out_eol  = sk_vld ? sk_eol  : (r_vld & r_eol);
  assign out_eof  = sk_vld ? sk_eof  : (r_vld & r_eof);
  assign pop      = out_vld & m.ready;
  assign eof_pop  = pop & out_eof;

  assign m.valid = out_vld;
  assign m.data  = out_data;
  assign m.sof   = out_sof;
  assign m.eol   = out_eol;
  assign m.eof   = out_eof;

  // ---------------------------------------------------------------- checksum
`ifdef STREAM_CHECKSUM_EN
  logic [15:0] acc;
  logic        sum_pulse;

  // Running sum of accepted beats, restarted by the sof beat; the total is
  // on frame_sum when sum_valid pulses the cycle after the eof beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc       <= '0;
      sum_pulse <= 1'b0;
    end else begin
      sum_pulse <= eof_pop;
      if (pop) acc <= (out_sof ? 16'd0 : acc) + 16'(out_data);
    end
  end

  assign frame_sum = acc;
  assign sum_valid = sum_pulse;
`else
  assign frame_sum = 16'd0;
  assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_reshape_frame_streamer.sv
// Bench for reshape_frame_streamer on a reduced 12x5 frame. A reference
// model (expected pixel queue + raster index arithmetic) checks every
// accepted beat; scenario table plus hand sequences for ping-pong and reset.
module tb_reshape_frame_streamer;
  localparam int W    = 12;
  localparam int H    = 5;
  localparam int NPIX = W * H;
  localparam int AW   = 20;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          frame_start;
  logic          in_wr_en;
  logic [AW-1:0] in_wr_addr;
  logic [DW-1:0] in_wr_data;
  logic          buf_ready;
  logic          ovf_err;
  logic [15:0]   frame_sum;
  logic          sum_valid;

  reshape_frame_streamer_if #(.DW(DW)) m_if ();

  reshape_frame_streamer #(.DST_W(W), .DST_H(H), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_start (frame_start),
    .in_wr_en    (in_wr_en),
    .in_wr_addr  (in_wr_addr),
    .in_wr_data  (in_wr_data),
    .buf_ready   (buf_ready),
    .m           (m_if),
    .ovf_err     (ovf_err),
    .frame_sum   (frame_sum),
    .sum_valid   (sum_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------ sink side
  int rdy_mode = 1;  // 0 hold low, 1 always ready, 2 random 50%

  // Downstream ready, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_if.ready = 1'b0;
      1:       m_if.ready = 1'b1;
      default: m_if.ready = 1'($urandom_range(0, 1));
    endcase
  end

  // reference model state
  logic [7:0] exp_q [$];
  int         bidx = 0;
  int         msum = 0;
  int         done_sum = 0;
  int         sum_pulses = 0;
  logic [15:0] last_sum = 16'd0;
  logic       prev_hold = 1'b0;
  logic       prev_eof = 1'b0;
  logic [10:0] prev_beat = '0;

  // Beat monitor: sampled mid-cycle, a beat transfers at the next rising edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rstn) begin
      bidx      = 0;
      msum      = 0;
      prev_hold = 1'b0;
      prev_eof  = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(m_if.valid), 32'd1);
        chk("hold_beat", 32'({m_if.data, m_if.sof, m_if.eol, m_if.eof}), 32'(prev_beat));
      end
`ifdef STREAM_CHECKSUM_EN
      chk("sum_valid", 32'(sum_valid), 32'(prev_eof));
      if (prev_eof) chk("frame_sum", 32'(frame_sum), done_sum & 32'hFFFF);
      if (sum_valid) begin
        sum_pulses++;
        last_sum = frame_sum;
      end
`else
      chk("sum_valid_off", 32'(sum_valid), 32'd0);
      chk("frame_sum_off", 32'(frame_sum), 32'd0);
`endif
      prev_eof = 1'b0;
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(m_if.data), 32'(e));
          chk("beat_marks", 32'({m_if.sof, m_if.eol, m_if.eof}),
              32'({bidx == 0, (bidx % W) == W - 1, bidx == NPIX - 1}));
          msum += int'(e);
          if (bidx == NPIX - 1) begin
            prev_eof = 1'b1;
            done_sum = msum;
            msum     = 0;
            bidx     = 0;
          end else begin
            bidx++;
          end
        end
      end
      prev_hold = m_if.valid && !m_if.ready;
      prev_beat = {m_if.data, m_if.sof, m_if.eol, m_if.eof};
    end
  end

  // ------------------------------------------------------------ drivers
  function automatic logic [7:0] pix(input int pat, input int a, input logic [7:0] k);
    case (pat)
      0:       return 8'(a % 256);
      1:       return k;
      default: return 8'($urandom);
    endcase
  endfunction

  // Write addresses 0..n-1 back-to-back (data one cycle behind the strobe).
  // Returns at the edge that commits the last pixel, plus 1 ns.
  task automatic write_frame(input int n, input int pat, input logic [7:0] k, input bit push);
    logic [7:0] d [NPIX];
    for (int i = 0; i < n; i++) d[i] = pix(pat, i, k);
    for (int i = 0; i < n; i++) begin
      frame_start = (i == 0);
      in_wr_en    = 1'b1;
      in_wr_addr  = AW'(i);
      if (i > 0) in_wr_data = d[i-1];
      tick;
    end
    frame_start = 1'b0;
    in_wr_en    = 1'b0;
    in_wr_data  = d[n-1];
    tick;
    if (push) for (int i = 0; i < NPIX; i++) exp_q.push_back(d[i]);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || m_if.valid) && n < 4000) begin
      tick;
      n++;
    end
    chk(nm, 32'(n < 4000), 32'd1);
    repeat (3) tick;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    repeat (2) tick;
    rstn = 1'b1;
    tick;
  endtask

  typedef struct {
    int         partial;  // writes of an aborted fill before the real frame
    int         pat;      // 0 ramp, 1 constant k, 2 random
    logic [7:0] k;
    int         rdy;
    int         exp_sum;  // -1: random data, model only
  } vec_t;

  vec_t tbl [6];

  initial begin
    int p0, n;
    tbl[0] = '{0,  0, 8'h00, 1, 1770};   // ramp 0..59
    tbl[1] = '{0,  0, 8'h00, 2, 1770};
    tbl[2] = '{25, 1, 8'h5A, 2, 5400};   // 90*60
    tbl[3] = '{0,  1, 8'h01, 1, 60};
    tbl[4] = '{59, 1, 8'hFF, 2, 15300};  // aborted fill stops one short of full
    tbl[5] = '{0,  2, 8'h00, 2, -1};

    rstn        = 1'b0;
    frame_start = 1'b0;
    in_wr_en    = 1'b0;
    in_wr_addr  = '0;
    in_wr_data  = '0;
    repeat (2) tick;
    chk("rst_buf_ready", 32'(buf_ready), 32'd1);
    chk("rst_valid", 32'(m_if.valid), 32'd0);
    chk("rst_marks", 32'({m_if.data, m_if.sof, m_if.eol, m_if.eof}), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_sum", 32'({sum_valid, frame_sum}), 32'd0);
    rstn = 1'b1;
    tick;

    // out-of-range address is dropped and flagged
    in_wr_en = 1'b1; in_wr_addr = AW'(NPIX); tick;
    in_wr_en = 1'b0; in_wr_data = 8'hAA;
    chk("oor_pre", 32'(ovf_err), 32'd0);
    tick;
    chk("oor_ovf", 32'(ovf_err), 32'd1);
    chk("oor_ready", 32'(buf_ready), 32'd1);
    do_reset;
    chk("oor_cleared", 32'(ovf_err), 32'd0);

    // scenario table
    for (int i = 0; i < 6; i++) begin
      rdy_mode = tbl[i].rdy;
      p0 = sum_pulses;
      if (tbl[i].partial > 0) begin
        write_frame(tbl[i].partial, 0, 8'h00, 1'b0);
        chk("partial_ready", 32'(buf_ready), 32'd1);
        repeat (2) tick;
        chk("partial_no_stream", 32'(m_if.valid), 32'd0);
      end
      write_frame(NPIX, tbl[i].pat, tbl[i].k, 1'b1);
      chk("fill_ready", 32'(buf_ready), 32'd1);
      chk("lat0", 32'(m_if.valid), 32'd0);
      tick;
      chk("lat1", 32'(m_if.valid), 32'd0);
      tick;
      chk("lat2", 32'({m_if.valid, m_if.sof}), 32'b11);
      wait_drain("tbl_drain");
`ifdef STREAM_CHECKSUM_EN
      chk("tbl_sum_pulses", 32'(sum_pulses - p0), 32'd1);
      if (tbl[i].exp_sum >= 0) chk("tbl_sum", 32'(last_sum), 32'(tbl[i].exp_sum));
`endif
    end

    // ping-pong: A held by back-pressure while B fills, extra write dropped
    rdy_mode = 0;
    repeat (2) tick;
    write_frame(NPIX, 0, 8'h00, 1'b1);
    repeat (2) tick;
    chk("pp_a_valid", 32'(m_if.valid), 32'd1);
    chk("pp_ready_a", 32'(buf_ready), 32'd1);
    write_frame(NPIX, 1, 8'h33, 1'b1);
    chk("pp_ready_b", 32'(buf_ready), 32'd0);
    chk("pp_ovf_pre", 32'(ovf_err), 32'd0);
    in_wr_en = 1'b1; in_wr_addr = AW'(3); tick;
    in_wr_en = 1'b0; in_wr_data = 8'h77; tick;
    chk("pp_ovf", 32'(ovf_err), 32'd1);
    chk("pp_hold", 32'({m_if.valid, m_if.data, m_if.sof}), 32'({1'b1, 8'h00, 1'b1}));
    rdy_mode = 1;
    wait_drain("pp_drain");
    chk("pp_ready_end", 32'(buf_ready), 32'd1);
    chk("pp_ovf_sticky", 32'(ovf_err), 32'd1);

    // reset in the middle of a streaming frame
    write_frame(NPIX, 0, 8'h00, 1'b1);
    n = 0;
    while (bidx < 20 && n < 500) begin
      tick;
      n++;
    end
    chk("mid_reach", 32'(n < 500), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_valid", 32'(m_if.valid), 32'd0);
    chk("mid_ready", 32'(buf_ready), 32'd1);
    chk("mid_ovf", 32'(ovf_err), 32'd0);
    exp_q.delete();
    repeat (2) tick;
    rstn = 1'b1;
    repeat (100) tick;
    chk("mid_quiet", 32'({m_if.valid, buf_ready}), 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
